// File: rtl/bp_nonsynth_commit_aligner.sv
// ============================================================================
// Module   : bp_nonsynth_commit_aligner
// Brief    : Pairs in-order commits with out-of-order register writebacks and
//            emits one in-order retire record per cycle for cosim/trace.
//            Optional watchdog: define BP_NONSYNTH_COMMIT_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_nonsynth_commit_aligner #(
    parameter int commit_width_p = 2,
    parameter int pc_width_p     = 39,
    parameter int data_width_p   = 64,
    parameter int reg_els_p      = 32,
    parameter int wb_els_p       = 8,
    parameter int commit_els_p   = 16,
    parameter int cnt_width_p    = 32,
    parameter int timeout_p      = 1024
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic [commit_width_p-1:0]                    commit_v_i,
    input  logic [commit_width_p*pc_width_p-1:0]         commit_pc_i,
    input  logic [commit_width_p*$clog2(reg_els_p)-1:0]  commit_rd_i,
    input  logic [commit_width_p-1:0]                    commit_wb_i,
    input  logic [commit_width_p-1:0]                    commit_trap_i,
    output logic                                         commit_ready_o,
    input  logic                                         wb_v_i,
    input  logic [$clog2(reg_els_p)-1:0]                 wb_addr_i,
    input  logic [data_width_p-1:0]                      wb_data_i,
    input  logic [cnt_width_p-1:0]                       instr_cap_i,
    output logic                                         retire_v_o,
    input  logic                                         retire_ready_i,
    output logic [pc_width_p-1:0]                        retire_pc_o,
    output logic [$clog2(reg_els_p)-1:0]                 retire_rd_o,
    output logic                                         retire_wb_o,
    output logic [data_width_p-1:0]                      retire_data_o,
    output logic                                         retire_trap_o,
    output logic [cnt_width_p-1:0]                       instr_cnt_o,
    output logic                                         finish_o,
    output logic                                         overflow_o,
    output logic                                         stall_o
);

    localparam int c_rd_w   = $clog2(reg_els_p);
    localparam int c_ptr_w  = (commit_els_p > 1) ? $clog2(commit_els_p) : 1;
    localparam int c_qcnt_w = $clog2(commit_els_p + 1);
    localparam int c_wptr_w = (wb_els_p > 1) ? $clog2(wb_els_p) : 1;
    localparam int c_wcnt_w = $clog2(wb_els_p + 1);

    if (commit_els_p < commit_width_p) begin : g_bad_depth
        $error("commit_els_p must be >= commit_width_p");
    end
    if (timeout_p < 1) begin : g_bad_timeout
        $error("timeout_p must be >= 1");
    end

    typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_e;
    state_e r_state;

    logic [pc_width_p-1:0]   r_cq_pc [commit_els_p];
    logic [c_rd_w-1:0]       r_cq_rd [commit_els_p];
    logic [commit_els_p-1:0] r_cq_wb, r_cq_trap;
    logic [c_ptr_w-1:0]      r_cq_head, r_cq_tail;
    logic [c_qcnt_w-1:0]     r_cq_cnt;

    logic [data_width_p-1:0] r_wb_mem [reg_els_p][wb_els_p];
    logic [c_wptr_w-1:0]     r_wb_rp  [reg_els_p];
    logic [c_wcnt_w-1:0]     r_wb_cnt [reg_els_p];

    logic [cnt_width_p-1:0]  r_instr_cnt;
    logic                    r_overflow;

    logic                    w_head_v, w_head_wb, w_head_trap, w_fifo_ne, w_fire, w_pop_wb;
    logic                    w_commit_any, w_enq, w_commit_drop, w_push_req, w_push_ok;
    logic [c_rd_w-1:0]       w_head_rd;
    logic [c_ptr_w-1:0]      w_slot [commit_width_p];
    logic [c_qcnt_w-1:0]     w_n_push, w_cq_cnt_next;
    logic [cnt_width_p-1:0]  w_cnt_inc;
    logic [c_wptr_w-1:0]     w_wb_wp;
    logic [reg_els_p-1:0]    w_wb_push, w_wb_pop;

    assign w_head_v    = (r_cq_cnt != '0);
    assign w_head_rd   = r_cq_rd[r_cq_head];
    assign w_head_wb   = r_cq_wb[r_cq_head];
    assign w_head_trap = r_cq_trap[r_cq_head];
    assign w_fifo_ne   = (r_wb_cnt[w_head_rd] != '0);

    assign retire_v_o    = w_head_v && (r_state != S_DONE) && (w_head_trap || !w_head_wb || w_fifo_ne);
    assign retire_pc_o   = w_head_v ? r_cq_pc[r_cq_head] : '0;
    assign retire_rd_o   = w_head_v ? w_head_rd : '0;
    assign retire_wb_o   = w_head_v && w_head_wb;
    assign retire_trap_o = w_head_v && w_head_trap;
    assign retire_data_o = (w_head_v && w_head_wb && w_fifo_ne) ?
                           r_wb_mem[w_head_rd][r_wb_rp[w_head_rd]] : '0;

    assign w_fire   = retire_v_o && retire_ready_i;
    assign w_pop_wb = w_fire && w_head_wb;

    // Gated by reset_i so the port reads 0 for the whole time reset is held.
    assign commit_ready_o = reset_i && (r_state == S_RUN) &&
                            (int'(r_cq_cnt) <= commit_els_p - commit_width_p);
    assign w_commit_any   = |commit_v_i;
    assign w_enq          = w_commit_any && commit_ready_o;
    assign w_commit_drop  = w_commit_any && !commit_ready_o;

    always_comb begin
        int ofs;
        ofs = 0;
        for (int l = 0; l < commit_width_p; l++) begin
            w_slot[l] = c_ptr_w'((int'(r_cq_tail) + ofs) % commit_els_p);
            if (commit_v_i[l]) ofs++;
        end
        w_n_push = c_qcnt_w'(ofs);
    end

    assign w_cq_cnt_next = r_cq_cnt + (w_enq ? w_n_push : '0) - c_qcnt_w'(w_fire);
    assign w_cnt_inc     = (r_instr_cnt == '1) ? r_instr_cnt : r_instr_cnt + 1'b1;

    // A full FIFO still accepts a push when its head is popped the same cycle.
    assign w_push_req = wb_v_i && (wb_addr_i != '0);
    assign w_push_ok  = w_push_req && ((int'(r_wb_cnt[wb_addr_i]) < wb_els_p) ||
                                       (w_pop_wb && (w_head_rd == wb_addr_i)));
    assign w_wb_wp    = c_wptr_w'((int'(r_wb_rp[wb_addr_i]) + int'(r_wb_cnt[wb_addr_i])) % wb_els_p);

    always_comb begin
        w_wb_push = '0;
        w_wb_pop  = '0;
        if (w_push_ok) w_wb_push[wb_addr_i] = 1'b1;
        if (w_pop_wb)  w_wb_pop[w_head_rd]  = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_wb_mem[wb_addr_i][w_wb_wp] <= wb_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= S_RUN;
            r_cq_head   <= '0;
            r_cq_tail   <= '0;
            r_cq_cnt    <= '0;
            r_cq_wb     <= '0;
            r_cq_trap   <= '0;
            r_instr_cnt <= '0;
            r_overflow  <= 1'b0;
            for (int r = 0; r < reg_els_p; r++) begin
                r_wb_rp[r]  <= '0;
                r_wb_cnt[r] <= '0;
            end
        end else begin
            if (w_enq) begin
                for (int l = 0; l < commit_width_p; l++) begin
                    if (commit_v_i[l]) begin
                        r_cq_pc[w_slot[l]]   <= commit_pc_i[l*pc_width_p +: pc_width_p];
                        r_cq_rd[w_slot[l]]   <= commit_rd_i[l*c_rd_w +: c_rd_w];
                        r_cq_wb[w_slot[l]]   <= commit_wb_i[l] && !commit_trap_i[l] &&
                                                (commit_rd_i[l*c_rd_w +: c_rd_w] != '0);
                        r_cq_trap[w_slot[l]] <= commit_trap_i[l];
                    end
                end
                r_cq_tail <= c_ptr_w'((int'(r_cq_tail) + int'(w_n_push)) % commit_els_p);
            end
            if (w_fire) r_cq_head <= c_ptr_w'((int'(r_cq_head) + 1) % commit_els_p);
            r_cq_cnt <= w_cq_cnt_next;

            for (int r = 0; r < reg_els_p; r++) begin
                r_wb_cnt[r] <= r_wb_cnt[r] + c_wcnt_w'(w_wb_push[r]) - c_wcnt_w'(w_wb_pop[r]);
                if (w_wb_pop[r]) r_wb_rp[r] <= c_wptr_w'((int'(r_wb_rp[r]) + 1) % wb_els_p);
            end

            r_overflow <= r_overflow || w_commit_drop || (w_push_req && !w_push_ok);

            case (r_state)
                S_RUN: begin
                    if (w_fire && !w_head_trap) begin
                        r_instr_cnt <= w_cnt_inc;
                        if ((instr_cap_i != '0) && (w_cnt_inc == instr_cap_i)) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: if (w_cq_cnt_next == '0) r_state <= S_DONE;
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign instr_cnt_o = r_instr_cnt;
    assign finish_o    = (r_state == S_DONE);
    assign overflow_o  = r_overflow;

`ifdef BP_NONSYNTH_COMMIT_WATCHDOG_EN
    localparam int c_wd_w = $clog2(timeout_p + 1);
    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_stall;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_fire || !w_head_v) r_wd_cnt <= '0;
            else if (int'(r_wd_cnt) < timeout_p) r_wd_cnt <= r_wd_cnt + 1'b1;
            if (!w_fire && w_head_v && (int'(r_wd_cnt) + 1 >= timeout_p)) r_stall <= 1'b1;
        end
    end
    assign stall_o = r_stall;
`else
    assign stall_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_nonsynth_commit_aligner.sv
// ============================================================================
// Module   : tb_bp_nonsynth_commit_aligner
// Brief    : Directed self-checking bench for bp_nonsynth_commit_aligner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_nonsynth_commit_aligner;

    localparam int CW   = 2;
    localparam int PCW  = 39;
    localparam int DW   = 64;
    localparam int RW   = 5;
    localparam int CNTW = 32;
`ifdef BP_NONSYNTH_COMMIT_WATCHDOG_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_i;
    logic [CW-1:0]     commit_v_i, commit_wb_i, commit_trap_i;
    logic [CW*PCW-1:0] commit_pc_i;
    logic [CW*RW-1:0]  commit_rd_i;
    logic              commit_ready_o;
    logic              wb_v_i;
    logic [RW-1:0]     wb_addr_i;
    logic [DW-1:0]     wb_data_i;
    logic [CNTW-1:0]   instr_cap_i;
    logic              retire_v_o, retire_ready_i;
    logic [PCW-1:0]    retire_pc_o;
    logic [RW-1:0]     retire_rd_o;
    logic              retire_wb_o, retire_trap_o;
    logic [DW-1:0]     retire_data_o;
    logic [CNTW-1:0]   instr_cnt_o;
    logic              finish_o, overflow_o, stall_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bp_nonsynth_commit_aligner dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .commit_v_i     (commit_v_i),
        .commit_pc_i    (commit_pc_i),
        .commit_rd_i    (commit_rd_i),
        .commit_wb_i    (commit_wb_i),
        .commit_trap_i  (commit_trap_i),
        .commit_ready_o (commit_ready_o),
        .wb_v_i         (wb_v_i),
        .wb_addr_i      (wb_addr_i),
        .wb_data_i      (wb_data_i),
        .instr_cap_i    (instr_cap_i),
        .retire_v_o     (retire_v_o),
        .retire_ready_i (retire_ready_i),
        .retire_pc_o    (retire_pc_o),
        .retire_rd_o    (retire_rd_o),
        .retire_wb_o    (retire_wb_o),
        .retire_data_o  (retire_data_o),
        .retire_trap_o  (retire_trap_o),
        .instr_cnt_o    (instr_cnt_o),
        .finish_o       (finish_o),
        .overflow_o     (overflow_o),
        .stall_o        (stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_commit(input logic [1:0] v, input logic [PCW-1:0] pc0, input logic [PCW-1:0] pc1,
                                input logic [RW-1:0] rd0, input logic [RW-1:0] rd1,
                                input logic [1:0] wb, input logic [1:0] trap);
        commit_v_i    = v;
        commit_pc_i   = {pc1, pc0};
        commit_rd_i   = {rd1, rd0};
        commit_wb_i   = wb;
        commit_trap_i = trap;
    endtask

    task automatic idle_commit();
        drive_commit(2'b00, '0, '0, '0, '0, 2'b00, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b0;
        idle_commit();
        wb_v_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        instr_cap_i = '0; retire_ready_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready", commit_ready_o, 0);
        chk("rst_rv", retire_v_o, 0);
        chk("rst_cnt", instr_cnt_o, 0);
        chk("rst_finish", finish_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_stall", stall_o, 0);
        reset_i = 1'b1; #1;
        chk("rel_ready", commit_ready_o, 1);

        // Dual-lane commit, writebacks arrive out of order
        tick();
        drive_commit(2'b11, 39'h100, 39'h104, 5'd5, 5'd6, 2'b11, 2'b00);
        tick(); idle_commit();
        chk("pair_wait0_rv", retire_v_o, 0);
        wb_v_i = 1'b1; wb_addr_i = 5'd6; wb_data_i = 64'hB;
        tick();
        chk("pair_wait1_rv", retire_v_o, 0);
        wb_addr_i = 5'd5; wb_data_i = 64'hA;
        tick(); wb_v_i = 1'b0;
        chk("pair0_rv", retire_v_o, 1);
        chk("pair0_pc", retire_pc_o, 39'h100);
        chk("pair0_rd", retire_rd_o, 5);
        chk("pair0_wb", retire_wb_o, 1);
        chk("pair0_data", retire_data_o, 64'hA);
        retire_ready_i = 1'b1;
        tick();
        chk("pair1_rv", retire_v_o, 1);
        chk("pair1_pc", retire_pc_o, 39'h104);
        chk("pair1_rd", retire_rd_o, 6);
        chk("pair1_data", retire_data_o, 64'hB);
        chk("pair1_cnt", instr_cnt_o, 1);
        tick();
        chk("pair_done_rv", retire_v_o, 0);
        chk("pair_done_cnt", instr_cnt_o, 2);
        retire_ready_i = 1'b0;

        // Trap on lane 0 (with wb requested, must be suppressed), plain on lane 1
        drive_commit(2'b11, 39'h200, 39'h204, 5'd3, 5'd0, 2'b01, 2'b01);
        tick(); idle_commit();
        chk("trap_rv", retire_v_o, 1);
        chk("trap_flag", retire_trap_o, 1);
        chk("trap_wb", retire_wb_o, 0);
        chk("trap_data", retire_data_o, 0);
        chk("trap_pc", retire_pc_o, 39'h200);
        retire_ready_i = 1'b1;
        tick();
        chk("plain_pc", retire_pc_o, 39'h204);
        chk("plain_trap", retire_trap_o, 0);
        chk("plain_wb", retire_wb_o, 0);
        chk("plain_cnt", instr_cnt_o, 2);
        tick();
        chk("trap_pair_cnt", instr_cnt_o, 3);
        chk("trap_pair_rv", retire_v_o, 0);
        retire_ready_i = 1'b0;

        // Fill the queue to 16 under back-pressure
        for (int k = 0; k < 8; k++) begin
            drive_commit(2'b11, 39'h300 + 39'(8*k), 39'h304 + 39'(8*k), 5'd0, 5'd0, 2'b00, 2'b00);
            tick();
        end
        idle_commit();
        chk("full_ready", commit_ready_o, 0);
        chk("full_rv", retire_v_o, 1);
        chk("full_ovf_pre", overflow_o, 0);
        drive_commit(2'b01, 39'h7FF, 39'h0, 5'd1, 5'd0, 2'b00, 2'b00);
        for (int k = 0; k < 10; k++) begin
            tick(); idle_commit();
            chk("bp_head_pc", retire_pc_o, 39'h300);
            chk("bp_ready", commit_ready_o, 0);
        end
        chk("bp_ovf", overflow_o, 1);
        retire_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_pc", retire_pc_o, 64'h300 + 64'(4*k));
            tick();
        end
        chk("drain_cnt", instr_cnt_o, 19);
        chk("drain_rv", retire_v_o, 0);
        retire_ready_i = 1'b0;

        // Asynchronous reset with 5 entries queued
        drive_commit(2'b11, 39'h400, 39'h404, 5'd0, 5'd0, 2'b00, 2'b00); tick();
        drive_commit(2'b11, 39'h408, 39'h40C, 5'd0, 5'd0, 2'b00, 2'b00); tick();
        drive_commit(2'b01, 39'h410, 39'h0,   5'd0, 5'd0, 2'b00, 2'b00); tick();
        idle_commit();
        chk("mid_rv", retire_v_o, 1);
        chk("mid_pc", retire_pc_o, 39'h400);
        reset_i = 1'b0; #1;
        chk("arst_rv", retire_v_o, 0);
        chk("arst_cnt", instr_cnt_o, 0);
        chk("arst_ready", commit_ready_o, 0);
        chk("arst_ovf", overflow_o, 0);
        tick(); reset_i = 1'b1; #1;
        chk("arel_ready", commit_ready_o, 1);
        chk("arel_rv", retire_v_o, 0);

        // Instruction cap of 3 with 6 queued
        instr_cap_i = 32'd3;
        tick();
        drive_commit(2'b11, 39'h500, 39'h504, 5'd0, 5'd0, 2'b00, 2'b00); tick();
        drive_commit(2'b11, 39'h508, 39'h50C, 5'd0, 5'd0, 2'b00, 2'b00); tick();
        drive_commit(2'b11, 39'h510, 39'h514, 5'd0, 5'd0, 2'b00, 2'b00); tick();
        idle_commit();
        chk("cap_rv0", retire_v_o, 1);
        retire_ready_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("cap_cnt", instr_cnt_o, (k < 3) ? 64'(k) : 64'd3);
            chk("cap_finish", finish_o, (k == 6) ? 1 : 0);
            if (k == 3) begin
                chk("drain_ready", commit_ready_o, 0);
                chk("drain_head_pc", retire_pc_o, 39'h50C);
            end
        end
        chk("done_rv", retire_v_o, 0);
        drive_commit(2'b01, 39'h600, 39'h0, 5'd0, 5'd0, 2'b00, 2'b00);
        instr_cap_i = '0;
        tick(); idle_commit();
        tick();
        chk("done_hold", finish_o, 1);
        chk("done_rv2", retire_v_o, 0);
        chk("done_cnt", instr_cnt_o, 3);
        chk("done_ready", commit_ready_o, 0);
        chk("done_ovf", overflow_o, 1);

        // Watchdog: commit x7 with writeback that never arrives
        reset_i = 1'b0;
        tick(); reset_i = 1'b1;
        tick();
        drive_commit(2'b01, 39'h700, 39'h0, 5'd7, 5'd0, 2'b01, 2'b00);
        retire_ready_i = 1'b1;
        tick(); idle_commit();
        chk("wd_rv", retire_v_o, 0);
        chk("wd_stall0", stall_o, 0);
        for (int k = 1; k < 1024; k++) tick();
        chk("wd_stall_1023", stall_o, 0);
        tick();
        chk("wd_stall_1024", stall_o, WD_EN);
        tick();
        chk("wd_stall_sticky", stall_o, WD_EN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_nonsynth_commit_aligner.md
Name: bp_nonsynth_commit_aligner

Overview:
Non-synthesizable, multi-lane commit/writeback aligner for cosimulation and trace back-ends.
- Accepts up to commit_width_p committed instructions per cycle and out-of-order register writebacks.
- Pairs each committed instruction with its writeback data.
- Emits one in-order retire record per cycle on a valid/ready interface to a checker or tracer.
- Counts retired instructions, raises finish at an instruction cap, then drains the queue. Sticky error flags report overflow and stalls.

Parameters:
commit_width_p, 2, commit lanes per cycle; lane 0 is oldest.
pc_width_p, 39, PC width.
data_width_p, 64, writeback data width.
reg_els_p, 32, architectural registers; address width is clog2(reg_els_p).
wb_els_p, 8, per-register writeback FIFO depth.
commit_els_p, 16, commit queue depth; must be >= commit_width_p.
cnt_width_p, 32, width of the instruction counter and the cap.
timeout_p, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
clk_i  in  1  clock, posedge.
reset_i  in  1  reset, asynchronous, active-low.
commit_v_i  in  commit_width_p  per-lane commit valid.
commit_pc_i  in  commit_width_p*pc_width_p  per-lane PC.
commit_rd_i  in  commit_width_p*clog2(reg_els_p)  per-lane destination register.
commit_wb_i  in  commit_width_p  lane instruction writes rd.
commit_trap_i  in  commit_width_p  lane is a trap (exception/interrupt), not a retire.
commit_ready_o  out  1  free slots >= commit_width_p and state is RUN.
wb_v_i  in  1  register writeback valid.
wb_addr_i  in  clog2(reg_els_p)  writeback register.
wb_data_i  in  data_width_p  writeback data.
instr_cap_i  in  cnt_width_p  retire cap; 0 disables the cap.
retire_v_o  out  1  head record valid.
retire_ready_i  in  1  consumer accepts the head record.
retire_pc_o  out  pc_width_p  head PC.
retire_rd_o  out  clog2(reg_els_p)  head rd.
retire_wb_o  out  1  head carries data.
retire_data_o  out  data_width_p  head data; 0 when retire_wb_o=0.
retire_trap_o  out  1  head is a trap.
instr_cnt_o  out  cnt_width_p  count of non-trap retirements.
finish_o  out  1  DONE state reached.
overflow_o  out  1  sticky: commit or writeback was dropped.
stall_o  out  1  sticky watchdog flag.

Behaviour:
Reset:
- While reset_i=0 (takes effect immediately, asynchronously), all queues are empty, state is RUN, and every output is 0.
- commit_ready_o rises combinationally once reset_i=1.

Commit enqueue:
- Valid lanes are compacted in lane order into the circular commit queue in a single cycle.
- Wrap-around at commit_els_p is handled by a modulo pointer.
- commit_wb_i with commit_rd_i=0 is stored as wb=0.
- Any commit_v_i bit asserted while commit_ready_o=0: all lanes that cycle are dropped and overflow_o is set.

Writeback fill:
- wb_v_i with wb_addr_i!=0 pushes into the FIFO for that register.
- Writebacks to x0 are discarded.
- A push into a full FIFO is dropped and sets overflow_o.
- A push and a pop on the same FIFO in the same cycle are legal, including when the FIFO is full.

Retire (combinational from the queue head):
- retire_v_o = head valid & (trap | ~wb | FIFO[rd] non-empty).
- Zero-cycle bypass of a same-cycle writeback is not required. Minimum commit-to-retire latency is 1 cycle.
- A retire fires when retire_v_o & retire_ready_i. It pops the head and, if wb=1, pops FIFO[rd].
- retire_trap_o=1 forces retire_wb_o=0.
- Head record outputs hold stable while retire_v_o=1 and retire_ready_i=0.

Counter:
- instr_cnt_o increments on a firing non-trap retire and saturates at all-ones.

State machine:
- RUN -> DRAIN when instr_cap_i!=0 and the count equals the cap after an increment.
- In DRAIN: commit_ready_o=0, and commits still arriving set overflow_o. Retirement continues; the counter stops at the cap.
- DRAIN -> DONE when the commit queue is empty.
- In DONE: finish_o=1, retire_v_o=0. DONE is held until reset.
- Changing instr_cap_i after RUN has been left has no effect.

Optional Feature:
BP_NONSYNTH_COMMIT_WATCHDOG_EN
- Defined: a cycle counter clears on every retire fire and on an empty queue, and increments while the head is valid and not firing.
- Reaching timeout_p sets stall_o. stall_o is sticky until reset; behaviour is otherwise unchanged.
- Undefined: the counter is absent and stall_o is tied 0.

Test Plan:
- Reset mid-stream with 5 queued commits: drop reset_i to 0 -> same cycle retire_v_o=0, instr_cnt_o=0; after release the queue is empty and commit_ready_o=1.
- Lanes 0,1 commit x5, x6 in the same cycle; wb x6=0xB arrives before wb x5=0xA -> retires in order: x5/0xA, then x6/0xB. instr_cnt_o=2.
- retire_ready_i=0 for 10 cycles with 16 queued -> commit_ready_o=0. A commit that cycle sets overflow_o; the head record is unchanged throughout.
- Trap on lane 0 and plain retire with no wb on lane 1 -> trap record with retire_wb_o=0, then the plain record. Count increments by 1 only.
- instr_cap_i=3 with 6 commits queued -> count stops at 3, remaining entries drain, finish_o=1 after the queue empties, retire_v_o=0 afterwards.
- Watchdog enabled, timeout_p=1024: commit x7 with wb and never write x7 -> stall_o=1 exactly 1024 cycles after the head becomes valid. With the macro undefined, stall_o stays 0.
